// File: rtl/axi4_mem_pkg.sv
// Shared encodings and FSM state types for the AXI4 burst memory slave.
package axi4_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED, INCR and WRAP bursts.
// Oversized AxSIZE is clamped to the bus width; WRAP with an illegal length
// and the reserved burst type both behave as INCR.
module axi4_burst_addr_gen
  import axi4_mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  localparam int MAX_SIZE = $clog2(DATA_W/8);

  logic [2:0]        eff_size;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] wrap_base;
  logic              wrap_ok;

  // Next address: step by the clamped size, fold back at the wrap window end
  always_comb begin
    eff_size   = (size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size;
    step       = ADDR_W'(1) << eff_size;
    incr_addr  = addr + step;
    wrap_ok    = (burst == BURST_WRAP) &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    wrap_bytes = ADDR_W'({1'b0, len} + 9'd1) << eff_size;
    wrap_base  = addr & ~(wrap_bytes - ADDR_W'(1));
    next_addr  = incr_addr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if (wrap_ok && (incr_addr == wrap_base + wrap_bytes)) begin
      next_addr = wrap_base;
    end
  end

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 full slave over an on-chip word memory with independent write and
// read engines, byte strobes, ID echo and FIXED/INCR/WRAP bursts.
// Optional macro AXI_MEM_RANGE_CHECK_EN: beats whose word index lies at or
// beyond MEM_DEPTH are dropped (write) or return zero (read) with SLVERR;
// without it the word index simply wraps modulo MEM_DEPTH.
module axi4_burst_mem_slave
  import axi4_mem_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int MEM_DEPTH          = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int IDW      = C_S_AXI_ID_WIDTH;
  localparam int STRB_W   = DW/8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH);

  function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
    return a[ADDR_LSB +: IDX_W];
  endfunction

`ifdef AXI_MEM_RANGE_CHECK_EN
  function automatic logic in_range(input logic [AW-1:0] a);
    logic [AW-1:0] widx;
    widx = a >> ADDR_LSB;
    return widx < AW'(MEM_DEPTH);
  endfunction
`endif

  logic [DW-1:0] mem [MEM_DEPTH];

  logic init_done;

  wr_state_t     wstate, wstate_nxt;
  logic [IDW-1:0] wid;
  logic [AW-1:0] waddr, waddr_nxt;
  logic [7:0]    wlen, wcnt;
  logic [2:0]    wsize;
  logic [1:0]    wburst;
  logic          werr;
  logic          aw_hs, w_hs, w_oor;

  rd_state_t     rstate, rstate_nxt;
  logic [IDW-1:0] rid;
  logic [AW-1:0] raddr, raddr_nxt;
  logic [7:0]    rlen, rcnt;
  logic [2:0]    rsize;
  logic [1:0]    rburst;
  logic [DW-1:0] rdata_p1;
  logic          rerr_p1;
  logic          ar_hs, r_hs, r_oor;

  axi4_burst_addr_gen #(.ADDR_W(AW), .DATA_W(DW)) u_wr_addr_gen (
    .addr(waddr), .len(wlen), .size(wsize), .burst(wburst), .next_addr(waddr_nxt)
  );

  axi4_burst_addr_gen #(.ADDR_W(AW), .DATA_W(DW)) u_rd_addr_gen (
    .addr(raddr), .len(rlen), .size(rsize), .burst(rburst), .next_addr(raddr_nxt)
  );

`ifdef AXI_MEM_RANGE_CHECK_EN
  assign w_oor = !in_range(waddr);
  assign r_oor = !in_range(raddr);
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  & S_AXI_RREADY;

  // Hold both address channels off for the first cycle after reset release
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) init_done <= 1'b0;
    else                init_done <= 1'b1;
  end

  // Write engine state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wstate <= W_IDLE;
    else                wstate <= wstate_nxt;
  end

  // Write engine next state and handshake outputs
  always_comb begin
    wstate_nxt    = wstate;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (wstate)
      W_IDLE: begin
        S_AXI_AWREADY = init_done;
        if (S_AXI_AWVALID && init_done) wstate_nxt = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && (wcnt == wlen)) wstate_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  assign S_AXI_BID   = wid;
  assign S_AXI_BRESP = werr ? RESP_SLVERR : RESP_OKAY;

  // Write burst context: captured AW fields, beat counter, sticky error
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wid    <= '0;
      waddr  <= '0;
      wlen   <= '0;
      wsize  <= '0;
      wburst <= '0;
      wcnt   <= '0;
      werr   <= 1'b0;
    end else if (aw_hs) begin
      wid    <= S_AXI_AWID;
      waddr  <= S_AXI_AWADDR;
      wlen   <= S_AXI_AWLEN;
      wsize  <= S_AXI_AWSIZE;
      wburst <= S_AXI_AWBURST;
      wcnt   <= '0;
      werr   <= 1'b0;
    end else if (w_hs) begin
      waddr  <= waddr_nxt;
      wcnt   <= wcnt + 8'd1;
      werr   <= werr | (S_AXI_WLAST != (wcnt == wlen)) | w_oor;
    end
  end

  // Byte-lane memory write for each accepted beat
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_hs && !w_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) mem[word_idx(waddr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read engine state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rstate <= R_IDLE;
    else                rstate <= rstate_nxt;
  end

  // Read engine next state and read-channel outputs
  always_comb begin
    rstate_nxt    = rstate;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RDATA   = '0;
    S_AXI_RRESP   = RESP_OKAY;
    S_AXI_RLAST   = 1'b0;
    case (rstate)
      R_IDLE: begin
        S_AXI_ARREADY = init_done;
        if (S_AXI_ARVALID && init_done) rstate_nxt = R_ADDR;
      end
      R_ADDR: rstate_nxt = R_DATA;
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RDATA  = rdata_p1;
        S_AXI_RRESP  = rerr_p1 ? RESP_SLVERR : RESP_OKAY;
        S_AXI_RLAST  = (rcnt == rlen);
        if (S_AXI_RREADY) rstate_nxt = (rcnt == rlen) ? R_IDLE : R_ADDR;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  assign S_AXI_RID = rid;

  // Read burst context: captured AR fields, beat counter, per-beat error
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rid     <= '0;
      raddr   <= '0;
      rlen    <= '0;
      rsize   <= '0;
      rburst  <= '0;
      rcnt    <= '0;
      rerr_p1 <= 1'b0;
    end else begin
      if (ar_hs) begin
        rid    <= S_AXI_ARID;
        raddr  <= S_AXI_ARADDR;
        rlen   <= S_AXI_ARLEN;
        rsize  <= S_AXI_ARSIZE;
        rburst <= S_AXI_ARBURST;
        rcnt   <= '0;
      end else if (r_hs && (rcnt != rlen)) begin
        raddr  <= raddr_nxt;
        rcnt   <= rcnt + 8'd1;
      end
      if (rstate == R_ADDR) rerr_p1 <= r_oor;
    end
  end

  // Stage p1: registered memory read; a same-cycle write leaves old data here
  always_ff @(posedge S_AXI_ACLK) begin
    if (rstate == R_ADDR) rdata_p1 <= r_oor ? '0 : mem[word_idx(raddr)];
  end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Scoreboard bench for axi4_burst_mem_slave: drivers queue expected B and R
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_axi4_burst_mem_slave;
  import axi4_mem_pkg::*;

  localparam int DW = 32, AW = 12, IDW = 4, DEPTH = 256;

  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic aresetn;
  logic [IDW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  axi4_burst_mem_slave #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_ID_WIDTH(IDW), .MEM_DEPTH(DEPTH)
  ) dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [IDW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  int n_vec = 0;
  int n_err = 0;

  logic chk_zero = 1'b0;
  logic chk_ready = 1'b0;
  logic [DW-1:0] wdat [16];
  logic [DW-1:0] rexp [16];
  logic pat [4];

  logic hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic [IDW-1:0] hold_id;
  logic hold_last;

  // Monitor: compares every presented response against the scoreboard head
  always @(negedge tb_ACLK) begin
    b_exp_t be;
    r_exp_t re;
    if (chk_zero) begin
      n_vec++;
      if ({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast} != '0) begin
        n_err++;
        $display("FAIL reset_outputs: got aw=%0b w=%0b b=%0b bid=%0h bresp=%0h ar=%0b r=%0b rid=%0h rdata=%h rresp=%0h rlast=%0b, expected all 0",
                 awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast);
      end
    end
    if (chk_ready) begin
      n_vec++;
      if (!(awready === 1'b1 && arready === 1'b1)) begin
        n_err++;
        $display("FAIL ready_after_reset: got awready=%0b arready=%0b, expected 1 1", awready, arready);
      end
    end
    if (aresetn) begin
      if (bvalid && bready) begin
        n_vec++;
        if (bq.size() == 0) begin
          n_err++;
          $display("FAIL b_unexpected: got bid=%0h bresp=%0h, expected no response", bid, bresp);
        end else begin
          be = bq.pop_front();
          if (bid !== be.id || bresp !== be.resp) begin
            n_err++;
            $display("FAIL b_resp: got bid=%0h bresp=%0h, expected bid=%0h bresp=%0h", bid, bresp, be.id, be.resp);
          end
        end
      end
      if (rvalid) begin
        if (hold_pend) begin
          n_vec++;
          if (rdata !== hold_data || rid !== hold_id || rlast !== hold_last) begin
            n_err++;
            $display("FAIL r_stall_hold: got rdata=%h rid=%0h rlast=%0b, expected rdata=%h rid=%0h rlast=%0b",
                     rdata, rid, rlast, hold_data, hold_id, hold_last);
          end
        end
        hold_pend = !rready;
        hold_data = rdata;
        hold_id   = rid;
        hold_last = rlast;
        if (rready) begin
          n_vec++;
          if (rq.size() == 0) begin
            n_err++;
            $display("FAIL r_unexpected: got rid=%0h rdata=%h, expected no beat", rid, rdata);
          end else begin
            re = rq.pop_front();
            if (rid !== re.id || rdata !== re.data || rresp !== re.resp || rlast !== re.last) begin
              n_err++;
              $display("FAIL r_beat: got rid=%0h rdata=%h rresp=%0h rlast=%0b, expected rid=%0h rdata=%h rresp=%0h rlast=%0b",
                       rid, rdata, rresp, rlast, re.id, re.data, re.resp, re.last);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [IDW-1:0] id, input logic [AW-1:0] a,
                         input logic [7:0] len, input logic [1:0] burst);
    int t;
    awid = id; awaddr = a; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (t <= 200) begin
      @(negedge tb_ACLK);
      if (awready) break;
      t++;
    end
    if (t > 200) begin
      n_vec++; n_err++;
      $display("FAIL aw_timeout: awready=%0b, expected 1", awready);
    end
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic l);
    int t;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    t = 0;
    while (t <= 200) begin
      @(negedge tb_ACLK);
      if (wready) break;
      t++;
    end
    if (t > 200) begin
      n_vec++; n_err++;
      $display("FAIL w_timeout: wready=%0b, expected 1", wready);
    end
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic write_burst(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                             input logic [1:0] burst, input logic [DW/8-1:0] s, input int last_at,
                             input logic [1:0] exp_resp);
    bq.push_back('{id, exp_resp});
    send_aw(id, a, len, burst);
    for (int i = 0; i <= int'(len); i++) send_w(wdat[i], s, (i == last_at));
  endtask

  task automatic read_burst(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input logic [1:0] exp_resp);
    int t;
    for (int i = 0; i <= int'(len); i++) rq.push_back('{id, rexp[i], exp_resp, (i == int'(len))});
    arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (t <= 200) begin
      @(negedge tb_ACLK);
      if (arready) break;
      t++;
    end
    if (t > 200) begin
      n_vec++; n_err++;
      $display("FAIL ar_timeout: arready=%0b, expected 1", arready);
    end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic stall_reader();
    int k;
    k = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (rq.size() == 0) break;
      if (rvalid) begin
        rready = pat[k % 4];
        k++;
      end else begin
        rready = 1'b1;
      end
    end
    rready = 1'b1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (c < 1000 && (rq.size() != 0 || bq.size() != 0)) begin
      tick();
      c++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: pending r=%0d b=%0d, expected 0 0", rq.size(), bq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    #2 aresetn = 1'b0;
    repeat (3) tick();

    // Outputs low during reset and for one cycle after release, then ready
    chk_zero = 1'b1;
    tick();
    aresetn = 1'b1;
    tick();
    chk_zero = 1'b0;
    chk_ready = 1'b1;
    tick();
    chk_ready = 1'b0;

    // INCR write of 16 words, INCR read back with ID echo
    wdat = '{32'h00abcdef, 32'h11111111, 32'h22222222, 32'h33333333,
             32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
             32'h88888888, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB,
             32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};
    write_burst(4'd1, 12'h000, 8'd15, BURST_INCR, 4'hF, 15, RESP_OKAY);
    drain();
    for (int i = 0; i < 16; i++) rexp[i] = wdat[i];
    read_burst(4'd2, 12'h000, 8'd15, BURST_INCR, RESP_OKAY);
    drain();

    // WRAP read from word 8 of the 64-byte window: words 8..15 then 0..7
    for (int i = 0; i < 16; i++) rexp[i] = wdat[(8 + i) % 16];
    read_burst(4'd3, 12'h020, 8'd15, BURST_WRAP, RESP_OKAY);
    drain();

    // FIXED write to word 4 with low-half strobes: last beat's low half over 0x44444444
    wdat[0] = 32'hA0A01111; wdat[1] = 32'hB0B02222; wdat[2] = 32'hC0C03333; wdat[3] = 32'hD0D05A5A;
    write_burst(4'd5, 12'h010, 8'd3, BURST_FIXED, 4'b0011, 3, RESP_OKAY);
    drain();
    rexp[0] = 32'h44445A5A;
    read_burst(4'd4, 12'h010, 8'd0, BURST_INCR, RESP_OKAY);
    drain();

    // Reserved burst and WRAP with len=2 both step as INCR
    rexp[0] = 32'h00abcdef; rexp[1] = 32'h11111111; rexp[2] = 32'h22222222; rexp[3] = 32'h33333333;
    read_burst(4'd14, 12'h000, 8'd3, 2'b11, RESP_OKAY);
    drain();
    rexp[0] = 32'h22222222; rexp[1] = 32'h33333333; rexp[2] = 32'h44445A5A;
    read_burst(4'd15, 12'h008, 8'd2, BURST_WRAP, RESP_OKAY);
    drain();

    // Stalled 4-beat read concurrent with an independent 8-beat write
    for (int i = 0; i < 4; i++) wdat[i] = 32'hC0DE0000 + 32'(i);
    write_burst(4'd6, 12'h040, 8'd3, BURST_INCR, 4'hF, 3, RESP_OKAY);
    drain();
    for (int i = 0; i < 4; i++) rexp[i] = 32'hC0DE0000 + 32'(i);
    for (int i = 0; i < 8; i++) wdat[i] = 32'hBEEF0000 + 32'(i);
    fork
      read_burst(4'd9, 12'h040, 8'd3, BURST_INCR, RESP_OKAY);
      write_burst(4'd8, 12'h080, 8'd7, BURST_INCR, 4'hF, 7, RESP_OKAY);
      stall_reader();
    join
    drain();
    for (int i = 0; i < 8; i++) rexp[i] = 32'hBEEF0000 + 32'(i);
    read_burst(4'd10, 12'h080, 8'd7, BURST_INCR, RESP_OKAY);
    drain();

    // Early WLAST on beat 2: all four beats still land, response is SLVERR
    for (int i = 0; i < 4; i++) wdat[i] = 32'h51000000 + 32'(i);
    write_burst(4'd7, 12'h100, 8'd3, BURST_INCR, 4'hF, 2, RESP_SLVERR);
    drain();
    for (int i = 0; i < 4; i++) rexp[i] = 32'h51000000 + 32'(i);
    read_burst(4'd11, 12'h100, 8'd3, BURST_INCR, RESP_OKAY);
    drain();

    // Missing WLAST on a 2-beat burst is also SLVERR
    wdat[0] = 32'h12345678; wdat[1] = 32'h9ABCDEF0;
    write_burst(4'd12, 12'h120, 8'd1, BURST_INCR, 4'hF, -1, RESP_SLVERR);
    drain();

    // Word index DEPTH: zero with SLVERR when checked, otherwise aliases word 0
`ifdef AXI_MEM_RANGE_CHECK_EN
    rexp[0] = 32'h00000000;
    read_burst(4'd13, 12'h400, 8'd0, BURST_INCR, RESP_SLVERR);
`else
    rexp[0] = 32'h00abcdef;
    read_burst(4'd13, 12'h400, 8'd0, BURST_INCR, RESP_OKAY);
`endif
    drain();

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
